// File: rtl/trigger_capture_ctrl.sv
// Threshold trigger and fixed-length capture controller feeding the sample FIFO.
// Optional hysteresis detector enabled by defining TRIG_HYST_EN.
module trigger_capture_ctrl #(
  parameter int DATA_SIZE    = 12,
  parameter int ADDR_SIZE    = 8,
  parameter int CAPTURE_LEN  = 256,
  parameter int AUTO_TIMEOUT = 1024,
  parameter int HYST         = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_SIZE-1:0] sample_data_i,
  input  logic                 sample_valid_i,
  input  logic [DATA_SIZE-1:0] threshold_i,
  input  logic [1:0]           edge_sel_i,
  input  logic [1:0]           mode_i,
  input  logic                 acquiring_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_full_i,
  output logic                 w_en_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 trigger_o,
  output logic [1:0]           state_o,
  output logic                 done_o
);

  localparam int CNT_W = ADDR_SIZE + 1;
  localparam int TO_W  = $clog2(AUTO_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LEN_V   = CNT_W'(CAPTURE_LEN);
  localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(CAPTURE_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = {TO_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t               state_q, state_d;
  logic                 empty_meta_q, empty_meta_d, empty_sync_q, empty_sync_d;
  logic                 full_meta_q, full_meta_d, full_sync_q, full_sync_d;
  logic                 prev_above_q, prev_above_d;
  logic                 w_en_q, w_en_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 trigger_q, trigger_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 above, rise, fall, evt;

`ifdef TRIG_HYST_EN
  localparam logic [DATA_SIZE-1:0] HYST_V = DATA_SIZE'(HYST);
  logic                 arm_rise_q, arm_rise_d, arm_fall_q, arm_fall_d;
  logic [DATA_SIZE-1:0] lo_thr, hi_thr;
  logic [DATA_SIZE:0]   hi_sum;
`endif

  always_comb begin
    above        = sample_data_i >= threshold_i;
    prev_above_d = sample_valid_i ? above : prev_above_q;
`ifdef TRIG_HYST_EN
    lo_thr = (threshold_i >= HYST_V) ? threshold_i - HYST_V : '0;
    hi_sum = {1'b0, threshold_i} + {1'b0, HYST_V};
    hi_thr = hi_sum[DATA_SIZE] ? {DATA_SIZE{1'b1}} : hi_sum[DATA_SIZE-1:0];
    // An armed flag guarantees the previous sample was on the far side of the threshold.
    rise = arm_rise_q & above & ~prev_above_q;
    fall = arm_fall_q & ~above & prev_above_q;
    arm_rise_d = arm_rise_q;
    arm_fall_d = arm_fall_q;
    if (sample_valid_i) begin
      if (rise) arm_rise_d = 1'b0;
      else if (sample_data_i < lo_thr) arm_rise_d = 1'b1;
      if (fall) arm_fall_d = 1'b0;
      else if (sample_data_i > hi_thr) arm_fall_d = 1'b1;
    end
`else
    rise = above & ~prev_above_q;
    fall = ~above & prev_above_q;
`endif
    case (edge_sel_i)
      2'd1:    evt = sample_valid_i & fall;
      2'd2:    evt = sample_valid_i & (rise | fall);
      default: evt = sample_valid_i & rise;
    endcase
  end

  always_comb begin
    empty_meta_d = fifo_empty_i;
    empty_sync_d = empty_meta_q;
    full_meta_d  = fifo_full_i;
    full_sync_d  = full_meta_q;
    state_d      = state_q;
    w_en_d       = 1'b0;
    data_d       = data_q;
    trigger_d    = evt;
    wr_cnt_d     = wr_cnt_q;
    to_cnt_d     = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (acquiring_i && empty_sync_q) begin
          state_d  = ARMED;
          to_cnt_d = '0;
        end
      end
      ARMED: begin
        if (evt) begin
          // The triggering sample is itself the first word of the record.
          state_d  = (CAPTURE_LEN == 1) ? DONE : CAPTURE;
          w_en_d   = 1'b1;
          data_d   = sample_data_i;
          wr_cnt_d = CNT_W'(1);
        end else if (mode_i == 2'd1 && to_cnt_q == TO_LAST) begin
          state_d  = CAPTURE;
          wr_cnt_d = '0;
        end
      end
      CAPTURE: begin
        if (full_sync_q) begin
          state_d = DONE;
        end else if (sample_valid_i && wr_cnt_q < LEN_V) begin
          w_en_d   = 1'b1;
          data_d   = sample_data_i;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_V) state_d = DONE;
        end
      end
      default: begin
        if (mode_i != 2'd2) state_d = IDLE;
      end
    endcase
    if (!acquiring_i) begin
      state_d = IDLE;
      w_en_d  = 1'b0;
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      empty_meta_q <= 1'b0;
      empty_sync_q <= 1'b0;
      full_meta_q  <= 1'b0;
      full_sync_q  <= 1'b0;
      prev_above_q <= 1'b0;
      w_en_q       <= 1'b0;
      data_q       <= '0;
      trigger_q    <= 1'b0;
      done_q       <= 1'b0;
      wr_cnt_q     <= '0;
      to_cnt_q     <= '0;
`ifdef TRIG_HYST_EN
      arm_rise_q   <= 1'b0;
      arm_fall_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      empty_meta_q <= empty_meta_d;
      empty_sync_q <= empty_sync_d;
      full_meta_q  <= full_meta_d;
      full_sync_q  <= full_sync_d;
      prev_above_q <= prev_above_d;
      w_en_q       <= w_en_d;
      data_q       <= data_d;
      trigger_q    <= trigger_d;
      done_q       <= done_d;
      wr_cnt_q     <= wr_cnt_d;
      to_cnt_q     <= to_cnt_d;
`ifdef TRIG_HYST_EN
      arm_rise_q   <= arm_rise_d;
      arm_fall_q   <= arm_fall_d;
`endif
    end
  end

  assign w_en_o    = w_en_q;
  assign data_o    = data_q;
  assign trigger_o = trigger_q;
  assign state_o   = state_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed bench for trigger_capture_ctrl with a write-data scoreboard.
module tb_trigger_capture_ctrl;

  logic        clk;
  logic        rst_i;
  logic [11:0] sample_data_i;
  logic        sample_valid_i;
  logic [11:0] threshold_i;
  logic [1:0]  edge_sel_i;
  logic [1:0]  mode_i;
  logic        acquiring_i;
  logic        fifo_empty_i;
  logic        fifo_full_i;
  logic        w_en_o;
  logic [11:0] data_o;
  logic        trigger_o;
  logic [1:0]  state_o;
  logic        done_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          trig_cnt = 0;
  logic [11:0] exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DONE = 2'd3;

  trigger_capture_ctrl #(
    .DATA_SIZE(12), .ADDR_SIZE(8), .CAPTURE_LEN(16), .AUTO_TIMEOUT(32), .HYST(64)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_data_i(sample_data_i), .sample_valid_i(sample_valid_i),
    .threshold_i(threshold_i), .edge_sel_i(edge_sel_i), .mode_i(mode_i),
    .acquiring_i(acquiring_i), .fifo_empty_i(fifo_empty_i), .fifo_full_i(fifo_full_i),
    .w_en_o(w_en_o), .data_o(data_o), .trigger_o(trigger_o), .state_o(state_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every observed write must match the next expected word.
  always @(negedge clk) begin
    if (w_en_o === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 32'd1);
      else chk("write_data", 32'(data_o), 32'(exp_q.pop_front()));
    end
    if (trigger_o === 1'b1) trig_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [11:0] s, input logic v);
    sample_data_i  = s;
    sample_valid_i = v;
    tick();
  endtask

  task automatic wait_state(input logic [1:0] st, input int max, input string tag);
    int k = 0;
    while (state_o !== st && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(state_o), 32'(st));
  endtask

  task automatic arm_from_low();
    acquiring_i = 1'b0;
    cyc(12'h700, 1'b1);
    acquiring_i = 1'b1;
    sample_valid_i = 1'b0;
    wait_state(S_ARMED, 6, "arm_wait");
  endtask

  initial begin
    int          w0, t0, k, extra;
    logic [11:0] s;
    rst_i = 1'b0; sample_data_i = '0; sample_valid_i = 1'b0; threshold_i = 12'h800;
    edge_sel_i = 2'd0; mode_i = 2'd0; acquiring_i = 1'b0; fifo_empty_i = 1'b1; fifo_full_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_en", 32'(w_en_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_trigger", 32'(trigger_o), 0);
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    chk("rst_done", 32'(done_o), 0);
    rst_i = 1'b1;
    repeat (3) tick();

    // Normal mode rising ramp.
    w0 = wr_cnt; t0 = trig_cnt; k = 0;
    acquiring_i = 1'b1;
    wait_state(S_ARMED, 6, "t1_armed");
    for (int i = 0; i < 33; i++) begin
      s = 12'h700 + 12'(16 * i);
      if (s >= 12'h800 && k < 16) begin exp_q.push_back(s); k++; end
      cyc(s, 1'b1);
      if (s == 12'h800) begin
        chk("t1_trig_pulse", 32'(trigger_o), 1);
        chk("t1_state_capture", 32'(state_o), 32'(S_CAPTURE));
        chk("t1_first_wen", 32'(w_en_o), 1);
        chk("t1_first_data", 32'(data_o), 32'h800);
      end
      if (s == 12'h8F0) begin
        chk("t1_state_done", 32'(state_o), 32'(S_DONE));
        chk("t1_done_o", 32'(done_o), 1);
      end
      if (s == 12'h900) chk("t1_state_idle", 32'(state_o), 32'(S_IDLE));
    end
    sample_valid_i = 1'b0;
    tick();
    chk("t1_write_count", 32'(wr_cnt - w0), 16);
    chk("t1_trig_count", 32'(trig_cnt - t0), 1);
    acquiring_i = 1'b0;
    tick();

    // Auto mode with a constant input that never crosses.
    mode_i = 2'd1;
    cyc(12'h100, 1'b1);
    w0 = wr_cnt; t0 = trig_cnt;
    acquiring_i = 1'b1;
    wait_state(S_ARMED, 6, "t2_armed");
    k = 0;
    while (state_o !== S_CAPTURE && k < 40) begin tick(); k++; end
    chk("t2_timeout_cycles", 32'(k), 32);
    chk("t2_forced_no_wen", 32'(w_en_o), 0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(12'h100);
      tick();
    end
    chk("t2_state_done", 32'(state_o), 32'(S_DONE));
    tick();
    chk("t2_state_idle", 32'(state_o), 32'(S_IDLE));
    chk("t2_write_count", 32'(wr_cnt - w0), 16);
    chk("t2_no_trigger", 32'(trig_cnt - t0), 0);
    acquiring_i = 1'b0;
    tick();

    // FIFO full asserted after the fifth write.
    mode_i = 2'd0;
    arm_from_low();
    fifo_empty_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(12'h800 + 12'(i));
      cyc(12'h800 + 12'(i), 1'b1);
      chk("t3_pre_full_wen", 32'(w_en_o), 1);
    end
    fifo_full_i = 1'b1;
    extra = 0;
    for (int i = 0; i < 8 && state_o !== S_DONE; i++) begin
      exp_q.push_back(12'h805 + 12'(i));
      cyc(12'h805 + 12'(i), 1'b1);
      if (w_en_o === 1'b1) extra++;
    end
    chk("t3_state_done", 32'(state_o), 32'(S_DONE));
    chk("t3_extra_le3", 32'(extra <= 3), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(12'h820 + 12'(i), 1'b1);
      chk("t3_no_wen_full", 32'(w_en_o), 0);
    end
    exp_q.delete();
    chk("t3_idle_not_empty", 32'(state_o), 32'(S_IDLE));
    fifo_empty_i = 1'b1; fifo_full_i = 1'b0; sample_valid_i = 1'b0;
    wait_state(S_ARMED, 5, "t3_rearm_empty");
    acquiring_i = 1'b0;
    tick();

    // Single-shot mode holds DONE until acquiring drops.
    mode_i = 2'd2;
    arm_from_low();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(12'h800 + 12'(i));
      cyc(12'h800 + 12'(i), 1'b1);
    end
    chk("t4_state_done", 32'(state_o), 32'(S_DONE));
    t0 = trig_cnt;
    for (int i = 0; i < 4; i++) begin
      cyc(12'h700, 1'b1);
      cyc(12'h900, 1'b1);
      chk("t4_hold_done", 32'(state_o), 32'(S_DONE));
      chk("t4_hold_done_o", 32'(done_o), 1);
    end
    acquiring_i = 1'b0;
    cyc(12'h900, 1'b0);
    chk("t4_idle_after_drop", 32'(state_o), 32'(S_IDLE));
    chk("t4_done_cleared", 32'(done_o), 0);
    chk("t4_trig_in_done", 32'(trig_cnt - t0), 4);
    acquiring_i = 1'b1;
    wait_state(S_ARMED, 5, "t4_rearm");
    acquiring_i = 1'b0;
    tick();

    // Detector noise immunity, invalid samples, either/falling edges (IDLE).
    mode_i = 2'd0;
    t0 = trig_cnt;
    for (int i = 0; i < 8; i++) begin
      cyc(12'h7F0, 1'b1);
      cyc(12'h810, 1'b1);
    end
    cyc(12'h7F0, 1'b1);
    cyc(12'h900, 1'b0);
    cyc(12'h7F0, 1'b1);
    cyc(12'h7F0, 1'b0);
`ifdef TRIG_HYST_EN
    chk("t5_noise_trigs", 32'(trig_cnt - t0), 0);
`else
    chk("t5_noise_trigs", 32'(trig_cnt - t0), 8);
`endif
    t0 = trig_cnt;
    cyc(12'h7B0, 1'b1);
    cyc(12'h810, 1'b1);
    cyc(12'h810, 1'b0);
    chk("t5_dip_rise_trigs", 32'(trig_cnt - t0), 1);
    chk("t5_stays_idle", 32'(state_o), 32'(S_IDLE));
    edge_sel_i = 2'd2;
    t0 = trig_cnt;
    cyc(12'h000, 1'b1);
    cyc(12'hFFF, 1'b1);
    cyc(12'h000, 1'b1);
    cyc(12'hFFF, 1'b1);
    cyc(12'hFFF, 1'b0);
`ifdef TRIG_HYST_EN
    chk("t5_either_trigs", 32'(trig_cnt - t0), 3);
`else
    chk("t5_either_trigs", 32'(trig_cnt - t0), 4);
`endif
    edge_sel_i = 2'd1;
    t0 = trig_cnt;
    cyc(12'h000, 1'b1);
    cyc(12'hFFF, 1'b1);
    cyc(12'h000, 1'b1);
    cyc(12'h000, 1'b0);
    chk("t5_fall_trigs", 32'(trig_cnt - t0), 2);
    edge_sel_i = 2'd0;

    // Abort mid-capture, then reset mid-armed.
    arm_from_low();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(12'h800 + 12'(i));
      cyc(12'h800 + 12'(i), 1'b1);
    end
    chk("t6_in_capture", 32'(state_o), 32'(S_CAPTURE));
    acquiring_i = 1'b0;
    cyc(12'h804, 1'b1);
    chk("t6_abort_idle", 32'(state_o), 32'(S_IDLE));
    chk("t6_abort_wen", 32'(w_en_o), 0);
    chk("t6_abort_done", 32'(done_o), 0);
    acquiring_i = 1'b1;
    sample_valid_i = 1'b0;
    wait_state(S_ARMED, 6, "t6_armed");
    rst_i = 1'b0;
    tick();
    chk("t6_rst_state", 32'(state_o), 32'(S_IDLE));
    chk("t6_rst_wen", 32'(w_en_o), 0);
    chk("t6_rst_data", 32'(data_o), 0);
    chk("t6_rst_trigger", 32'(trigger_o), 0);
    chk("t6_rst_done", 32'(done_o), 0);
    rst_i = 1'b1;
    acquiring_i = 1'b0;
    tick();
    chk("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
